// File: rtl/bit_scan_8b_pkg.sv
// Shared definitions for the set-bit scanner: default mask width, index width
// derivation and the scanner state encoding.
package bit_scan_8b_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic int idx_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/bit_scan_8b_pri_enc.sv
// Combinational priority encoder: highest set bit of mask_i as index and one-hot,
// with zero_o flagging an all-zero mask (index and one-hot are 0 then).
module bit_scan_8b_pri_enc
  import bit_scan_8b_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  // Ascending scan so the highest set bit is the one left standing.
  always_comb begin
    idx_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      idx_o  = mask_i[i] ? IDX_W'(i) : idx_o;
      zero_o = mask_i[i] ? 1'b0 : zero_o;
    end
    onehot_o = zero_o ? '0 : (WIDTH'(1) << idx_o);
  end

endmodule

// File: rtl/bit_scan_8b.sv
// Sequential set-bit scanner: takes a flag mask over valid/ready and emits one
// beat per set bit, MSB first, or a single empty beat for an all-zero mask.
module bit_scan_8b
  import bit_scan_8b_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_mask_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [WIDTH-1:0] out_onehot_o,
  output logic             out_last_o,
  output logic             out_empty_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] resid_q, resid_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic             last_q, last_d;
  logic             empty_q, empty_d;

  logic             accept_s;
  logic [WIDTH-1:0] enc_in_s;
  logic [WIDTH-1:0] enc_onehot_s;
  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_zero_s;
  logic [WIDTH-1:0] enc_rest_s;

  // A new mask can enter when idle or as the final beat of the current one retires.
  assign in_ready_o = (state_q == ST_IDLE) | (valid_q & out_ready_i & last_q);
  assign accept_s   = in_valid_i & in_ready_o;

  // One encoder serves both the first beat (fresh mask) and every following beat.
  assign enc_in_s   = accept_s ? in_mask_i : resid_q;
  assign enc_rest_s = enc_in_s & ~enc_onehot_s;

  bit_scan_8b_pri_enc #(
    .WIDTH (WIDTH)
  ) u_pri_enc (
    .mask_i   (enc_in_s),
    .onehot_o (enc_onehot_s),
    .idx_o    (enc_idx_s),
    .zero_o   (enc_zero_s)
  );

  // Next-state and next-beat selection.
  always_comb begin
    state_d  = state_q;
    resid_d  = resid_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    last_d   = last_q;
    empty_d  = empty_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_SCAN;
          valid_d  = 1'b1;
          idx_d    = enc_idx_s;
          onehot_d = enc_onehot_s;
          empty_d  = enc_zero_s;
          last_d   = (enc_rest_s == '0);
          resid_d  = enc_rest_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (out_ready_i) begin
          if (accept_s | ~last_q) begin
            state_d  = ST_SCAN;
            valid_d  = 1'b1;
            idx_d    = enc_idx_s;
            onehot_d = enc_onehot_s;
            empty_d  = enc_zero_s;
            last_d   = (enc_rest_s == '0);
            resid_d  = enc_rest_s;
          end else begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            idx_d    = '0;
            onehot_d = '0;
            last_d   = 1'b0;
            empty_d  = 1'b0;
            resid_d  = '0;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        valid_d  = 1'b0;
        idx_d    = '0;
        onehot_d = '0;
        last_d   = 1'b0;
        empty_d  = 1'b0;
        resid_d  = '0;
      end
    endcase
  end

  // State, residual mask and output beat registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      resid_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      last_q   <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      resid_q  <= resid_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      last_q   <= last_d;
      empty_q  <= empty_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_idx_o    = idx_q;
  assign out_onehot_o = onehot_q;
  assign out_last_o   = last_q;
  assign out_empty_o  = empty_q;

endmodule

// File: tb/tb_bit_scan_8b.sv
// Scoreboard bench for bit_scan_8b: directed masks plus random masks under
// random backpressure, expected beats derived from the set bits of each mask.
module tb_bit_scan_8b;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] in_mask_i = 8'h00;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [2:0] out_idx_o;
  logic [7:0] out_onehot_o;
  logic       out_last_o;
  logic       out_empty_o;

  bit_scan_8b dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_mask_i    (in_mask_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_idx_o    (out_idx_o),
    .out_onehot_o (out_onehot_o),
    .out_last_o   (out_last_o),
    .out_empty_o  (out_empty_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          pushed_now = 0;
  int          bp_mode = 0;
  int          bp_cnt = 0;
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] saved_beat = 32'd0;
  logic [31:0] cur_beat;
  logic [31:0] want_beat;

  function automatic logic [31:0] pk(input int idx, input logic [7:0] oh,
                                     input bit last, input bit empty);
    return {19'd0, 3'(idx), oh, last, empty};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endfunction

  // Reference: one beat per set bit from the top down, or one empty beat.
  function automatic void push_expect(input logic [7:0] m);
    int bits[$];
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) bits.push_back(i);
    end
    if (bits.size() == 0) begin
      exp_q.push_back(pk(0, 8'h00, 1'b1, 1'b1));
      pushed_now += 1;
    end else begin
      for (int k = 0; k < bits.size(); k++) begin
        exp_q.push_back(pk(bits[k], 8'(1 << bits[k]), k == bits.size() - 1, 1'b0));
      end
      pushed_now += bits.size();
    end
  endfunction

  // Consumer backpressure pattern, refreshed each cycle.
  always @(negedge clk_i) begin
    pushed_now = 0;
    case (bp_mode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = 1'($urandom_range(0, 1));
      2: begin
        out_ready_i = (bp_cnt % 3 == 0);
        bp_cnt++;
      end
      default: out_ready_i = 1'b1;
    endcase
  end

  // Monitor: latency/no-bubble, ready rule, stall stability, beat content.
  always @(negedge clk_i) begin
    #2;
    if (mon_en && rst_n_i) begin
      cur_beat = pk(int'(out_idx_o), out_onehot_o, out_last_o, out_empty_o);
      chk("out_valid", 32'(out_valid_o), 32'(exp_q.size() > pushed_now));
      chk("in_ready", 32'(in_ready_o), 32'(!out_valid_o || (out_ready_i && out_last_o)));
      if (stall_prev && out_valid_o) chk("stall_hold", cur_beat, saved_beat);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", cur_beat, 32'hffff_ffff);
        end else begin
          want_beat = exp_q.pop_front();
          chk("beat", cur_beat, want_beat);
        end
      end
      stall_prev = out_valid_o && !out_ready_i;
      saved_beat = cur_beat;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [7:0] m);
    int guard = 0;
    in_valid_i = 1'b1;
    in_mask_i  = m;
    #1;
    while (!in_ready_o && guard < 200) begin
      @(negedge clk_i);
      #1;
      guard++;
    end
    chk("accept_timeout", 32'(in_ready_o), 32'd1);
    if (in_ready_o) push_expect(m);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    in_mask_i  = 8'($urandom);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    #2;
    chk("reset_outputs", {27'd0, out_valid_o, out_idx_o, out_last_o}, 32'd0);
    chk("reset_onehot_empty", {23'd0, out_onehot_o, out_empty_o}, 32'd0);
    chk("reset_in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk_i);

    bp_mode = 0;
    send(8'h7a);
    idle(8);
    send(8'h00);
    idle(3);
    send(8'hff);
    send(8'h4f);
    idle(16);
    bp_mode = 2;
    bp_cnt  = 0;
    send(8'hcd);
    idle(20);

    // Reset while the third beat of 8'haa is on the bus.
    bp_mode = 0;
    send(8'haa);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("midscan_reset_outputs",
        {18'd0, out_valid_o, out_idx_o, out_onehot_o, out_last_o, out_empty_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("ready_after_reset", 32'(in_ready_o), 32'd1);
    idle(6);

    bp_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      send(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    in_valid_i = 1'b0;
    for (int g = 0; g < 500 && exp_q.size() != 0; g++) @(negedge clk_i);
    chk("drain", 32'(exp_q.size()), 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
